fuel_volume_counter: RTL and testbench
======================================

// Module: fuel_volume_counter
// PURPOSE
//  Dispensing controller for the automatic fuel pump, one stage upstream of the 7-seg decoders.
//  Latches a BCD preset volume, opens the valve on start and counts flow-meter pulses in BCD.
//  Closes the valve when the count reaches the preset or on stop.
//  Each 4-bit digit of cnt feeds one display decoder (0..9 per digit).
// PARAMETERS
//  DIGITS          3           number of BCD digits in preset and count
//  TIMEOUT_CYCLES  50_000_000  no-flow timeout in clk cycles (used only with FUEL_TIMEOUT_EN)
// PORTS
//  clk          in   1         system clock, all state on rising edge
//  rst_n        in   1         asynchronous active-low reset
//  preset_bcd   in   4*DIGITS  preset volume, BCD, digit 0 (LSD) at [3:0]
//  preset_load  in   1         1-cycle strobe: capture preset_bcd
//  start        in   1         1-cycle strobe: begin fill
//  stop         in   1         1-cycle strobe: abort fill
//  flow_pulse   in   1         raw flow-meter pulse, asynchronous to clk, 1 pulse = 1 unit
//  cnt          out  4*DIGITS  dispensed volume, BCD, digit 0 at [3:0]
//  valve_on     out  1         pump valve enable
//  busy         out  1         1 while PUMPING
//  done         out  1         1 while DONE
//  fault        out  1         no-flow timeout flag (always 0 without FUEL_TIMEOUT_EN)
// BEHAVIOUR
//  Reset (async assert): state=IDLE; cnt, preset, valve_on, busy, done, fault = 0; sync flops = 0.
//  All outputs registered. busy and done are decoded from the state register.
//  Preset: preset_load captures preset_bcd in IDLE or DONE only; ignored in PUMPING.
//   Any input digit >9 is stored as 9.
//  Flow sync: flow_pulse -> s1 -> s2 -> s3. Edge = s2 & ~s3.
//   cnt updates 2 clk edges after the edge that first samples flow_pulse high.
//   One increment per rising edge of flow_pulse, regardless of pulse width.
//  FSM states IDLE, PUMPING, DONE:
//   IDLE/DONE + start, preset != 0: cnt <= 0, fault <= 0, valve_on <= 1, -> PUMPING.
//   IDLE/DONE + start, preset == 0: ignored; stay in state, cnt unchanged.
//   PUMPING + flow edge: cnt <= cnt+1 (BCD with digit carry: 0x099 -> 0x100).
//    If cnt+1 == preset, the same edge sets valve_on <= 0 and state -> DONE.
//   PUMPING + stop: valve_on <= 0, -> DONE; cnt holds.
//   PUMPING + stop + flow edge in the same cycle: increment is applied, then -> DONE.
//   stop and start in the same cycle: stop wins; start is ignored in every state.
//   Flow edges outside PUMPING are ignored; cnt holds its last value in IDLE and DONE.
//  No wrap: preset <= all-9s and counting stops at preset, so cnt never exceeds 10^DIGITS-1.
//  Reset asserted mid-fill: valve_on drops asynchronously and the fill is lost.
// CONFIGURATION
//  FUEL_TIMEOUT_EN defined:
//   - An idle timer clears on entry to PUMPING and on every flow edge.
//   - If the timer reaches TIMEOUT_CYCLES-1 in PUMPING: valve_on <= 0, fault <= 1, -> DONE.
//   - fault clears on an accepted start or on preset_load.
//   - If the timeout and a flow edge fall in the same cycle, the flow edge wins (timer clears).
//  FUEL_TIMEOUT_EN undefined: no timer logic; fault is tied to 0.
// STRUCTURE
//  Package fuel_pkg: state encoding (IDLE/PUMPING/DONE) and BCD_W=4.
//   BCD_MAX=4'd9 and the digit-clamp function also belong there.
//  Sub-module bcd_digit: one cascadable BCD counter digit.
//   Ports: clr, inc_in, q[3:0], carry_out. Instantiated DIGITS times with a generate loop.
//  Top-level: synchronizer, edge detect, FSM, preset register, compare, optional timer.
// TESTING (DIGITS=3)
//  Load 0x012, start, 12 flow pulses:
//   cnt reads 0x009 after 9 pulses and 0x012 after 12; valve_on=0 and done=1 on that edge.
//   A 13th pulse leaves cnt=0x012.
//  Load 0x105, start, 105 pulses: cnt steps 0x099 -> 0x100 (carry), ends at 0x105 with done=1.
//  Load 0x050, start, 5 pulses, then stop: cnt=0x005 held, done=1.
//   Stop and start in the same cycle: stays in DONE.
//  Load 0x0A3: preset stored as 0x093. Load 0x000, then start: state stays IDLE, valve_on=0.
//  Reset pulled low mid-fill (cnt=0x007): cnt=0, valve_on=0 immediately, state IDLE.
//  FUEL_TIMEOUT_EN, TIMEOUT_CYCLES=100, start with no pulses:
//   fault=1, valve_on=0, done=1 after 100 cycles.
//   A new start clears fault.

Source files
------------

// File: rtl/fuel_pkg.sv
// Shared types and helpers for the fuel volume counter: FSM encoding, BCD digit width
// and the preset digit clamp.
package fuel_pkg;

    localparam int BCD_W = 4;
    localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PUMPING = 2'd1,
        DONE    = 2'd2
    } state_t;

    function automatic logic [BCD_W-1:0] clamp_digit(input logic [BCD_W-1:0] d);
        return (d > BCD_MAX) ? BCD_MAX : d;
    endfunction

endpackage

// File: rtl/fuel_volume_counter_if.sv
// Pump-side bus of the fuel volume counter: preset/strobes/flow in, count and status out.
// master = pump controller / bench side, slave = fuel_volume_counter.
interface fuel_volume_counter_if #(parameter int DIGITS = 3);

    logic [4*DIGITS-1:0] preset_bcd;
    logic                preset_load;
    logic                start;
    logic                stop;
    logic                flow_pulse;
    logic [4*DIGITS-1:0] cnt;
    logic                valve_on;
    logic                busy;
    logic                done;
    logic                fault;

    modport master (
        output preset_bcd, preset_load, start, stop, flow_pulse,
        input  cnt, valve_on, busy, done, fault
    );

    modport slave (
        input  preset_bcd, preset_load, start, stop, flow_pulse,
        output cnt, valve_on, busy, done, fault
    );

endinterface

// File: rtl/fuel_volume_counter_bcd_digit.sv
// One cascadable BCD counter digit (0..9); carry_out fires when an increment rolls 9 -> 0.
module bcd_digit
    import fuel_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             inc_in,
    output logic [BCD_W-1:0] q,
    output logic             carry_out
);

    assign carry_out = inc_in && (q == BCD_MAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (inc_in) begin
            q <= (q == BCD_MAX) ? '0 : q + 4'd1;
        end
    end

endmodule

// File: rtl/fuel_volume_counter.sv
// Fuel dispensing controller: latches a BCD preset, opens the valve on start and counts
// synchronised flow-meter edges in BCD until preset or stop. Optional no-flow timeout: FUEL_TIMEOUT_EN.
module fuel_volume_counter
    import fuel_pkg::*;
#(
    parameter int DIGITS         = 3,
    parameter int TIMEOUT_CYCLES = 50_000_000
) (
    input  logic clk,
    input  logic rst_n,
    fuel_volume_counter_if.slave bus
);

    localparam int W = BCD_W * DIGITS;

    logic         s1, s2, s3;
    logic         flow_edge;
    logic [W-1:0] preset;
    logic [W-1:0] cnt;
    logic [W-1:0] cnt_plus1;
    logic [DIGITS:0] carry;
    state_t       state;
    logic         valve_on;
    logic         start_ok;
    logic         inc;
    logic         reach;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= bus.flow_pulse;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign flow_edge = s2 && !s3;
    assign start_ok  = bus.start && !bus.stop && (state != PUMPING) && (preset != '0);
    assign inc       = (state == PUMPING) && flow_edge;

    assign carry[0] = inc;
    for (genvar i = 0; i < DIGITS; i++) begin : g_digit
        bcd_digit u_digit (
            .clk       (clk),
            .rst_n     (rst_n),
            .clr       (start_ok),
            .inc_in    (carry[i]),
            .q         (cnt[i*BCD_W +: BCD_W]),
            .carry_out (carry[i+1])
        );
    end

    always_comb begin
        logic             c;
        logic [BCD_W-1:0] d;
        c         = 1'b1;
        d         = '0;
        cnt_plus1 = '0;
        for (int i = 0; i < DIGITS; i++) begin
            d = cnt[i*BCD_W +: BCD_W];
            if (c && (d == BCD_MAX)) begin
                cnt_plus1[i*BCD_W +: BCD_W] = '0;
            end else if (c) begin
                cnt_plus1[i*BCD_W +: BCD_W] = d + 4'd1;
                c = 1'b0;
            end else begin
                cnt_plus1[i*BCD_W +: BCD_W] = d;
            end
        end
    end

    // A carry out of the top digit would mean a wrap; treat it as terminal too.
    assign reach = inc && ((cnt_plus1 == preset) || carry[DIGITS]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            preset <= '0;
        end else if (bus.preset_load && (state != PUMPING)) begin
            for (int i = 0; i < DIGITS; i++) begin
                preset[i*BCD_W +: BCD_W] <= clamp_digit(bus.preset_bcd[i*BCD_W +: BCD_W]);
            end
        end
    end

`ifdef FUEL_TIMEOUT_EN
    localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [TW-1:0] timer;
    logic          timeout;
    logic          fault;

    // Down-counter from TIMEOUT_CYCLES-1; terminal count 0 equals "idle for TIMEOUT_CYCLES-1 cycles".
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer <= '0;
        end else if (start_ok || flow_edge) begin
            timer <= TW'(TIMEOUT_CYCLES - 1);
        end else if ((state == PUMPING) && (timer != '0)) begin
            timer <= timer - 1'b1;
        end
    end

    assign timeout   = (state == PUMPING) && (timer == '0) && !flow_edge;
    assign bus.fault = fault;
`else
    assign bus.fault = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            valve_on <= 1'b0;
`ifdef FUEL_TIMEOUT_EN
            fault    <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start_ok) begin
                        valve_on <= 1'b1;
                        state    <= PUMPING;
                    end
`ifdef FUEL_TIMEOUT_EN
                    if (start_ok || bus.preset_load) begin
                        fault <= 1'b0;
                    end
`endif
                end
                PUMPING: begin
                    if (reach || bus.stop) begin
                        valve_on <= 1'b0;
                        state    <= DONE;
`ifdef FUEL_TIMEOUT_EN
                    end else if (timeout) begin
                        valve_on <= 1'b0;
                        fault    <= 1'b1;
                        state    <= DONE;
`endif
                    end
                end
                default: begin
                    valve_on <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

    assign bus.cnt      = cnt;
    assign bus.valve_on = valve_on;
    assign bus.busy     = (state == PUMPING);
    assign bus.done     = (state == DONE);

endmodule

// File: tb/tb_fuel_volume_counter.sv
// Directed bench for fuel_volume_counter (DIGITS=3): fill to preset, BCD carry, stop,
// preset clamp/zero, async reset mid-fill, and the no-flow timeout when FUEL_TIMEOUT_EN is set.
module tb_fuel_volume_counter;

    localparam int DIGITS = 3;
    localparam int W      = 4 * DIGITS;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    fuel_volume_counter_if #(.DIGITS(DIGITS)) bus ();

    fuel_volume_counter #(.DIGITS(DIGITS), .TIMEOUT_CYCLES(100)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [W-1:0] v);
        tick();
        bus.preset_bcd  = v;
        bus.preset_load = 1'b1;
        tick();
        bus.preset_load = 1'b0;
    endtask

    task automatic do_start();
        tick();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic do_stop();
        tick();
        bus.stop = 1'b1;
        tick();
        bus.stop = 1'b0;
    endtask

    // Pulse high for two cycles, low for three: the count settles before the task returns.
    task automatic pulse(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            bus.flow_pulse = 1'b1;
            tick();
            tick();
            bus.flow_pulse = 1'b0;
            tick();
            tick();
        end
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        bus.preset_bcd  = '0;
        bus.preset_load = 1'b0;
        bus.start       = 1'b0;
        bus.stop        = 1'b0;
        bus.flow_pulse  = 1'b0;
        apply_reset();
        checks++; if (bus.cnt !== 12'h000) begin errors++; $display("FAIL reset_cnt got %h exp %h", bus.cnt, 12'h000); end
        checks++; if (bus.valve_on !== 1'b0) begin errors++; $display("FAIL reset_valve got %b exp 0", bus.valve_on); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", bus.busy); end
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", bus.done); end
        checks++; if (bus.fault !== 1'b0) begin errors++; $display("FAIL reset_fault got %b exp 0", bus.fault); end
    endtask

    task automatic test_zero_preset();
        do_load(12'h000);
        do_start();
        tick();
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL zero_busy got %b exp 0", bus.busy); end
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL zero_done got %b exp 0", bus.done); end
        checks++; if (bus.valve_on !== 1'b0) begin errors++; $display("FAIL zero_valve got %b exp 0", bus.valve_on); end
        pulse(1);
        checks++; if (bus.cnt !== 12'h000) begin errors++; $display("FAIL zero_idle_cnt got %h exp %h", bus.cnt, 12'h000); end
    endtask

    task automatic test_fill_12();
        do_load(12'h012);
        do_start();
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL fill_busy got %b exp 1", bus.busy); end
        checks++; if (bus.valve_on !== 1'b1) begin errors++; $display("FAIL fill_valve_open got %b exp 1", bus.valve_on); end
        pulse(9);
        checks++; if (bus.cnt !== 12'h009) begin errors++; $display("FAIL fill_cnt9 got %h exp %h", bus.cnt, 12'h009); end
        pulse(2);
        checks++; if (bus.cnt !== 12'h011) begin errors++; $display("FAIL fill_cnt11 got %h exp %h", bus.cnt, 12'h011); end
        // 12th pulse by hand: cnt must change exactly two edges after the first sampling edge
        tick();
        bus.flow_pulse = 1'b1;
        tick();
        tick();
        checks++; if (bus.cnt !== 12'h011) begin errors++; $display("FAIL fill_latency got %h exp %h", bus.cnt, 12'h011); end
        checks++; if (bus.valve_on !== 1'b1) begin errors++; $display("FAIL fill_valve_before got %b exp 1", bus.valve_on); end
        tick();
        checks++; if (bus.cnt !== 12'h012) begin errors++; $display("FAIL fill_cnt12 got %h exp %h", bus.cnt, 12'h012); end
        checks++; if (bus.valve_on !== 1'b0) begin errors++; $display("FAIL fill_valve_closed got %b exp 0", bus.valve_on); end
        checks++; if (bus.done !== 1'b1) begin errors++; $display("FAIL fill_done got %b exp 1", bus.done); end
        bus.flow_pulse = 1'b0;
        tick();
        tick();
        pulse(1);
        checks++; if (bus.cnt !== 12'h012) begin errors++; $display("FAIL fill_13th got %h exp %h", bus.cnt, 12'h012); end
    endtask

    task automatic test_carry();
        do_load(12'h105);
        do_start();
        checks++; if (bus.cnt !== 12'h000) begin errors++; $display("FAIL carry_restart got %h exp %h", bus.cnt, 12'h000); end
        pulse(99);
        checks++; if (bus.cnt !== 12'h099) begin errors++; $display("FAIL carry_99 got %h exp %h", bus.cnt, 12'h099); end
        pulse(1);
        checks++; if (bus.cnt !== 12'h100) begin errors++; $display("FAIL carry_100 got %h exp %h", bus.cnt, 12'h100); end
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL carry_busy got %b exp 1", bus.busy); end
        pulse(5);
        checks++; if (bus.cnt !== 12'h105) begin errors++; $display("FAIL carry_105 got %h exp %h", bus.cnt, 12'h105); end
        checks++; if (bus.done !== 1'b1) begin errors++; $display("FAIL carry_done got %b exp 1", bus.done); end
    endtask

    task automatic test_stop();
        do_load(12'h050);
        do_start();
        pulse(5);
        do_stop();
        checks++; if (bus.cnt !== 12'h005) begin errors++; $display("FAIL stop_cnt got %h exp %h", bus.cnt, 12'h005); end
        checks++; if (bus.done !== 1'b1) begin errors++; $display("FAIL stop_done got %b exp 1", bus.done); end
        checks++; if (bus.valve_on !== 1'b0) begin errors++; $display("FAIL stop_valve got %b exp 0", bus.valve_on); end
        tick();
        bus.start = 1'b1;
        bus.stop  = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.stop  = 1'b0;
        tick();
        checks++; if (bus.done !== 1'b1) begin errors++; $display("FAIL startstop_done got %b exp 1", bus.done); end
        checks++; if (bus.valve_on !== 1'b0) begin errors++; $display("FAIL startstop_valve got %b exp 0", bus.valve_on); end
        pulse(2);
        checks++; if (bus.cnt !== 12'h005) begin errors++; $display("FAIL stop_hold got %h exp %h", bus.cnt, 12'h005); end
    endtask

    task automatic test_stop_with_edge();
        do_start();
        pulse(2);
        tick();
        bus.flow_pulse = 1'b1;
        tick();
        tick();
        bus.stop = 1'b1;
        tick();
        bus.stop = 1'b0;
        bus.flow_pulse = 1'b0;
        tick();
        checks++; if (bus.cnt !== 12'h003) begin errors++; $display("FAIL stopedge_cnt got %h exp %h", bus.cnt, 12'h003); end
        checks++; if (bus.done !== 1'b1) begin errors++; $display("FAIL stopedge_done got %b exp 1", bus.done); end
    endtask

    task automatic test_clamp();
        do_load(12'h0A3);
        do_start();
        do_load(12'h005);
        pulse(92);
        checks++; if (bus.cnt !== 12'h092) begin errors++; $display("FAIL clamp_cnt92 got %h exp %h", bus.cnt, 12'h092); end
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL clamp_busy got %b exp 1", bus.busy); end
        pulse(1);
        checks++; if (bus.cnt !== 12'h093) begin errors++; $display("FAIL clamp_cnt93 got %h exp %h", bus.cnt, 12'h093); end
        checks++; if (bus.done !== 1'b1) begin errors++; $display("FAIL clamp_done got %b exp 1", bus.done); end
    endtask

    task automatic test_reset_mid_fill();
        do_load(12'h050);
        do_start();
        pulse(7);
        checks++; if (bus.cnt !== 12'h007) begin errors++; $display("FAIL midrst_pre got %h exp %h", bus.cnt, 12'h007); end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++; if (bus.cnt !== 12'h000) begin errors++; $display("FAIL midrst_cnt got %h exp %h", bus.cnt, 12'h000); end
        checks++; if (bus.valve_on !== 1'b0) begin errors++; $display("FAIL midrst_valve got %b exp 0", bus.valve_on); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got %b exp 0", bus.busy); end
        tick();
        rst_n = 1'b1;
        tick();
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL midrst_idle got %b exp 0", bus.done); end
    endtask

`ifdef FUEL_TIMEOUT_EN
    task automatic test_timeout();
        int n;
        do_load(12'h010);
        do_start();
        n = 0;
        while (bus.done !== 1'b1 && n < 150) begin
            tick();
            n++;
        end
        checks++; if (n < 95 || n > 105) begin errors++; $display("FAIL timeout_cycles got %0d exp about 99", n); end
        checks++; if (bus.fault !== 1'b1) begin errors++; $display("FAIL timeout_fault got %b exp 1", bus.fault); end
        checks++; if (bus.valve_on !== 1'b0) begin errors++; $display("FAIL timeout_valve got %b exp 0", bus.valve_on); end
        do_start();
        checks++; if (bus.fault !== 1'b0) begin errors++; $display("FAIL timeout_clear got %b exp 0", bus.fault); end
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL timeout_restart got %b exp 1", bus.busy); end
        do_stop();
    endtask
`endif

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b1;
        test_reset();
        test_zero_preset();
        test_fill_12();
        test_carry();
        test_stop();
        test_stop_with_edge();
        test_clamp();
        test_reset_mid_fill();
`ifdef FUEL_TIMEOUT_EN
        test_timeout();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
